stopwatch_time_cnt: RTL and testbench
=====================================

Name: stopwatch_time_cnt

Overview:
- Time-base datapath driven by the stopwatch control state machine's clken and rst outputs; it is the consumer end of that control interface.
- Divides CLK into 1/100 s ticks and advances a BCD mm:ss.hh count while clken=1.
- A synchronous clear is taken from rst.
- Digit outputs feed the display/LCD driver.

Parameters:
TICK_DIV, 100000, CLK cycles per 1/100 s tick (10 MHz CLK); legal range >=1.
PW, $clog2(TICK_DIV) (min 1), prescaler width; derived, not overridden.

Ports:
CLK  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high reset.
clken  in  1  count enable from control FSM.
rst  in  1  synchronous clear from control FSM.
lap  in  1  lap pulse; present only with LAP_HOLD_EN.
hs_lo  out  4  hundredths units BCD, 0-9.
hs_hi  out  4  hundredths tens BCD, 0-9.
s_lo  out  4  seconds units BCD, 0-9.
s_hi  out  4  seconds tens BCD, 0-5.
m_lo  out  4  minutes units BCD, 0-9.
m_hi  out  4  minutes tens BCD, 0-5.
ovf  out  1  one-cycle pulse on wrap 59:59.99 -> 00:00.00.
running  out  1  registered copy of clken.

Behaviour:
- Async reset: prescaler, all digits, ovf, running, and the hold state all go to 0 immediately; all outputs registered.
- Priority per rising edge: rst > clken > idle.
  - rst=1: prescaler and all digits go to 0; ovf=0; clken ignored that cycle.
  - clken=1, rst=0: prescaler increments. When prescaler==TICK_DIV-1, it wraps to 0 and tick=1 in that same cycle.
  - clken=0, rst=0: prescaler and digits hold. Resume is seamless: the remaining count to the next tick is preserved across a pause.
- Tick latency: digits update at the same edge where the prescaler wraps. TICK_DIV=1 gives one tick per enabled cycle.
- BCD ripple on tick: hs_lo 9->0 carries to hs_hi; hs_hi 9->0 to s_lo; s_lo 9->0 to s_hi; s_hi 5->0 to m_lo; m_lo 9->0 to m_hi; m_hi 5->0 wraps.
  - All carries resolve in one cycle; no intermediate values are visible.
- Wrap: tick at 59:59.99 gives 00:00.00 and ovf=1 for exactly one cycle. Counting continues.
- Digit values outside the legal range are unreachable. If one appears (SEU), the next tick forces that digit to 0 and generates a carry.
- running: running <= clken & ~rst each cycle.

Optional Feature:
LAP_HOLD_EN
- Defined: lap port exists. A one-cycle lap pulse toggles the hold flag.
  - Setting hold captures the current digits (including any update in that cycle) into display registers.
  - While hold=1, the six digit outputs show the frozen snapshot; internal counting, ovf and running are unaffected.
  - Clearing hold returns the outputs to the live count on the next edge.
  - rst and reset clear hold.
  - lap while clken=0 still toggles.
- Undefined: no lap port, no snapshot registers; outputs are the live count.

Decomposition:
- stopwatch_pkg:
  - DIGIT_W=4.
  - Digit maxima HS_MAX=9, SEC_HI_MAX=5, MIN_HI_MAX=5.
  - typedef time_bcd_t: packed struct of six 4-bit digits.
  - Default TICK_DIV constant.
- Sub-module bcd_digit: parameter MAX; inputs CLK, reset, clr, inc; outputs q[3:0] and a combinational carry = inc & (q==MAX).
  - Instantiated six times, chained by carry.
  - The top level holds the prescaler, ovf, running and the optional hold logic.

Test Plan (TICK_DIV=4):
1. reset=1 mid-count at 00:03.27 -> all digits, ovf and running are 0 asynchronously, before the next edge.
2. rst=0, clken=1 for 400 cycles from zero -> 00:01.00. hs_lo increments every 4th cycle; the first change is on the 4th enabled edge.
3. clken=1 for 2 cycles, clken=0 for 10, clken=1 again -> first tick after exactly 2 more enabled cycles; digits constant during the pause.
4. Run to 59:59.99, then 4 more enabled cycles -> 00:00.00; ovf high for exactly that one cycle; the next tick gives 00:00.01 with ovf=0.
5. Count at 00:12.34 with clken=1 and rst=1 together for 3 cycles -> digits 00:00.00 after the first edge, still 0 after 3; running=0. Releasing rst gives the first tick 4 cycles later.
6. [LAP_HOLD_EN] lap at 00:05.00, run 200 more cycles -> outputs stay 00:05.00. Second lap -> live 00:05.50 on the next edge.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg
// Shared constants, types and helpers for the stopwatch time base.
//   DIGIT_W          width of one BCD digit
//   HS_MAX           top value of the decimal digits (units and hundredths tens)
//   SEC_HI_MAX       top value of the seconds tens digit
//   MIN_HI_MAX       top value of the minutes tens digit
//   TICK_DIV_DEFAULT CLK cycles per 1/100 s tick at 10 MHz
//   time_bcd_t       the six-digit mm:ss.hh value, most significant digit first
//   bcd_next()       next value of one digit, given its increment request
package stopwatch_pkg;

  localparam int DIGIT_W          = 4;
  localparam int HS_MAX           = 9;
  localparam int SEC_HI_MAX       = 5;
  localparam int MIN_HI_MAX       = 5;
  localparam int TICK_DIV_DEFAULT = 100000;

  typedef struct packed {
    logic [DIGIT_W-1:0] m_hi;
    logic [DIGIT_W-1:0] m_lo;
    logic [DIGIT_W-1:0] s_hi;
    logic [DIGIT_W-1:0] s_lo;
    logic [DIGIT_W-1:0] hs_hi;
    logic [DIGIT_W-1:0] hs_lo;
  } time_bcd_t;

  // A digit at or above its maximum rolls to 0. Values above the maximum
  // cannot occur in normal operation (only after an upset), and treating
  // them like the maximum puts the digit straight back into range.
  function automatic logic [DIGIT_W-1:0] bcd_next(input logic [DIGIT_W-1:0] q,
                                                  input logic               inc,
                                                  input int                 max);
    if (!inc)
      return q;
    else if (q >= DIGIT_W'(max))
      return '0;
    else
      return q + 1'b1;
  endfunction

endpackage

// File: rtl/stopwatch_time_cnt_bcd_digit.sv
// bcd_digit
// One BCD counter digit of the stopwatch chain.
//   CLK    in   clock, rising edge
//   reset  in   asynchronous active-high reset
//   clr    in   synchronous clear (wins over inc)
//   inc    in   advance this digit on this edge
//   q      out  registered digit value, 0..MAX
//   carry  out  combinational carry into the next digit (inc while at MAX)
module bcd_digit
  import stopwatch_pkg::*;
#(
  parameter int MAX = 9
) (
  input  logic               CLK,
  input  logic               reset,
  input  logic               clr,
  input  logic               inc,
  output logic [DIGIT_W-1:0] q,
  output logic               carry
);

  // ">=" rather than "==": an out-of-range digit also carries as it wraps to 0.
  assign carry = inc & (q >= DIGIT_W'(MAX));

  always_ff @(posedge CLK or posedge reset) begin
    if (reset)
      q <= '0;
    else if (clr)
      q <= '0;
    else
      q <= bcd_next(q, inc, MAX);
  end

endmodule

// File: rtl/stopwatch_time_cnt.sv
// stopwatch_time_cnt
// Stopwatch time base: divides CLK into 1/100 s ticks and keeps a BCD
// mm:ss.hh count while clken is high. rst is a synchronous clear from the
// control FSM and wins over clken.
//   CLK      in   system clock, rising edge
//   reset    in   asynchronous active-high reset
//   clken    in   count enable
//   rst      in   synchronous clear
//   lap      in   lap pulse, toggles display hold (only with LAP_HOLD_EN)
//   hs_lo..m_hi out  BCD digits for the display driver
//   ovf      out  one-cycle pulse on wrap 59:59.99 -> 00:00.00
//   running  out  registered clken & ~rst
// Build option: define LAP_HOLD_EN to add the lap port and the display
// snapshot; without it the digit outputs are always the live count.
module stopwatch_time_cnt
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
  input  logic               CLK,
  input  logic               reset,
  input  logic               clken,
  input  logic               rst,
`ifdef LAP_HOLD_EN
  input  logic               lap,
`endif
  output logic [DIGIT_W-1:0] hs_lo,
  output logic [DIGIT_W-1:0] hs_hi,
  output logic [DIGIT_W-1:0] s_lo,
  output logic [DIGIT_W-1:0] s_hi,
  output logic [DIGIT_W-1:0] m_lo,
  output logic [DIGIT_W-1:0] m_hi,
  output logic               ovf,
  output logic               running
);

  localparam int            PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] presc;
  logic          tick;
  time_bcd_t     live;
  time_bcd_t     disp;
  logic          c_hs_lo, c_hs_hi, c_s_lo, c_s_hi, c_m_lo, c_m_hi;

  // Tick fires on the same edge the prescaler wraps, so digits update there.
  assign tick = clken & ~rst & (presc == PRESC_LAST);

  // A pause simply holds the prescaler, so the partial period survives it.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset)
      presc <= '0;
    else if (rst)
      presc <= '0;
    else if (clken)
      presc <= tick ? '0 : presc + 1'b1;
  end

  // Digit chain; all carries are combinational so the ripple settles in one cycle.
  bcd_digit #(.MAX(HS_MAX)) u_hs_lo (
    .CLK(CLK), .reset(reset), .clr(rst), .inc(tick),
    .q(live.hs_lo), .carry(c_hs_lo)
  );
  bcd_digit #(.MAX(HS_MAX)) u_hs_hi (
    .CLK(CLK), .reset(reset), .clr(rst), .inc(c_hs_lo),
    .q(live.hs_hi), .carry(c_hs_hi)
  );
  bcd_digit #(.MAX(HS_MAX)) u_s_lo (
    .CLK(CLK), .reset(reset), .clr(rst), .inc(c_hs_hi),
    .q(live.s_lo), .carry(c_s_lo)
  );
  bcd_digit #(.MAX(SEC_HI_MAX)) u_s_hi (
    .CLK(CLK), .reset(reset), .clr(rst), .inc(c_s_lo),
    .q(live.s_hi), .carry(c_s_hi)
  );
  bcd_digit #(.MAX(HS_MAX)) u_m_lo (
    .CLK(CLK), .reset(reset), .clr(rst), .inc(c_s_hi),
    .q(live.m_lo), .carry(c_m_lo)
  );
  bcd_digit #(.MAX(MIN_HI_MAX)) u_m_hi (
    .CLK(CLK), .reset(reset), .clr(rst), .inc(c_m_lo),
    .q(live.m_hi), .carry(c_m_hi)
  );

  // Carry out of the top digit is exactly the 59:59.99 wrap; tick already
  // excludes rst, so a clear cycle leaves ovf low.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      ovf     <= 1'b0;
      running <= 1'b0;
    end else begin
      ovf     <= c_m_hi;
      running <= clken & ~rst;
    end
  end

`ifdef LAP_HOLD_EN
  logic      hold;
  time_bcd_t snap;
  time_bcd_t live_nxt;

  // Value the digits take on this edge, so a snapshot includes this cycle's tick.
  always_comb begin
    live_nxt       = live;
    live_nxt.hs_lo = bcd_next(live.hs_lo, tick,    HS_MAX);
    live_nxt.hs_hi = bcd_next(live.hs_hi, c_hs_lo, HS_MAX);
    live_nxt.s_lo  = bcd_next(live.s_lo,  c_hs_hi, HS_MAX);
    live_nxt.s_hi  = bcd_next(live.s_hi,  c_s_lo,  SEC_HI_MAX);
    live_nxt.m_lo  = bcd_next(live.m_lo,  c_s_hi,  HS_MAX);
    live_nxt.m_hi  = bcd_next(live.m_hi,  c_m_lo,  MIN_HI_MAX);
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      hold <= 1'b0;
      snap <= '0;
    end else if (rst) begin
      hold <= 1'b0;
    end else if (lap) begin
      hold <= ~hold;
      if (!hold)
        snap <= live_nxt;
    end
  end

  assign disp = hold ? snap : live;
`else
  assign disp = live;
`endif

  assign hs_lo = disp.hs_lo;
  assign hs_hi = disp.hs_hi;
  assign s_lo  = disp.s_lo;
  assign s_hi  = disp.s_hi;
  assign m_lo  = disp.m_lo;
  assign m_hi  = disp.m_hi;

endmodule

// File: tb/tb_stopwatch_time_cnt.sv
// tb_stopwatch_time_cnt
// Bench for stopwatch_time_cnt at TICK_DIV=4. A behavioural model (count in
// hundredths, converted to BCD) pushes the expected outputs of every cycle
// onto exp_q; each cycle's outputs are popped and compared #1 after the edge.
// A table of phases adds hand-computed checkpoints, followed by hand-written
// sequences for async reset, the 59:59.99 wrap and (with LAP_HOLD_EN) lap hold.
module tb_stopwatch_time_cnt;

  localparam int TD   = 4;
  localparam int FULL = 360000;

  // clock / reset
  logic CLK = 1'b0;
  logic reset;
  logic clken;
  logic rst;
`ifdef LAP_HOLD_EN
  logic lap;
`endif
  logic [3:0] hs_lo, hs_hi, s_lo, s_hi, m_lo, m_hi;
  logic       ovf;
  logic       running;
  logic [23:0] dig;

  always #5 CLK = ~CLK;

  assign dig = {m_hi, m_lo, s_hi, s_lo, hs_hi, hs_lo};

  stopwatch_time_cnt #(.TICK_DIV(TD)) dut (
    .CLK     (CLK),
    .reset   (reset),
    .clken   (clken),
    .rst     (rst),
`ifdef LAP_HOLD_EN
    .lap     (lap),
`endif
    .hs_lo   (hs_lo),
    .hs_hi   (hs_hi),
    .s_lo    (s_lo),
    .s_hi    (s_hi),
    .m_lo    (m_lo),
    .m_hi    (m_hi),
    .ovf     (ovf),
    .running (running)
  );

  // scoreboard
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [25:0] exp_q[$];

  // reference model state
  int   m_pre;
  int   m_cnt;
  logic m_ovf;
  logic m_run;
  logic m_hold;
  int   m_snap;

  typedef struct {
    logic        clken;
    logic        rst;
    int          cycles;
    logic [23:0] exp_t;
    logic        exp_run;
  } vec_t;

  vec_t vecs[12];

  function automatic logic [23:0] to_bcd(input int c);
    int hs, s, m;
    hs = c % 100;
    s  = (c / 100) % 60;
    m  = c / 6000;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(hs / 10), 4'(hs % 10)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pre  = 0;
    m_cnt  = 0;
    m_ovf  = 1'b0;
    m_run  = 1'b0;
    m_hold = 1'b0;
    m_snap = 0;
  endtask

  task automatic model_step(input logic c, input logic r, input logic l);
    if (r) begin
      m_pre  = 0;
      m_cnt  = 0;
      m_ovf  = 1'b0;
      m_hold = 1'b0;
    end else begin
      m_ovf = 1'b0;
      if (c) begin
        if (m_pre == TD - 1) begin
          m_pre = 0;
          m_cnt++;
          if (m_cnt == FULL) begin
            m_cnt = 0;
            m_ovf = 1'b1;
          end
        end else begin
          m_pre++;
        end
      end
      if (l) begin
        if (!m_hold) m_snap = m_cnt;
        m_hold = ~m_hold;
      end
    end
    m_run = c & ~r;
    exp_q.push_back({to_bcd(m_hold ? m_snap : m_cnt), m_ovf, m_run});
  endtask

  // driver: one clock with the given inputs, then compare against the scoreboard
  task automatic cycle(input logic c, input logic r, input logic l);
    logic [25:0] e;
    clken = c;
    rst   = r;
`ifdef LAP_HOLD_EN
    lap   = l;
`endif
    model_step(c, r, l);
    @(posedge CLK);
    #1;
`ifdef LAP_HOLD_EN
    lap = 1'b0;
`endif
    if (exp_q.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check("sb", 32'({dig, ovf, running}), 32'(e));
    end
  endtask

  task automatic run(input logic c, input logic r, input int n);
    for (int i = 0; i < n; i++) cycle(c, r, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // phases applied from 00:00.00 with the prescaler at 0
    vecs[0]  = '{1'b1, 1'b0, 3,    24'h000000, 1'b1};  // no change before 4th edge
    vecs[1]  = '{1'b1, 1'b0, 1,    24'h000001, 1'b1};  // first tick on 4th edge
    vecs[2]  = '{1'b1, 1'b0, 396,  24'h000100, 1'b1};  // 400 cycles -> 00:01.00
    vecs[3]  = '{1'b1, 1'b0, 2,    24'h000100, 1'b1};
    vecs[4]  = '{1'b0, 1'b0, 10,   24'h000100, 1'b0};  // pause holds digits
    vecs[5]  = '{1'b1, 1'b0, 1,    24'h000100, 1'b1};
    vecs[6]  = '{1'b1, 1'b0, 1,    24'h000101, 1'b1};  // tick after 2 more cycles
    vecs[7]  = '{1'b1, 1'b0, 4532, 24'h001234, 1'b1};
    vecs[8]  = '{1'b1, 1'b1, 1,    24'h000000, 1'b0};  // rst beats clken
    vecs[9]  = '{1'b1, 1'b1, 2,    24'h000000, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 4,    24'h000001, 1'b1};  // first tick 4 cycles after rst
    vecs[11] = '{1'b1, 1'b0, 1304, 24'h000327, 1'b1};

    reset = 1'b1;
    clken = 1'b0;
    rst   = 1'b0;
`ifdef LAP_HOLD_EN
    lap   = 1'b0;
`endif
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    check("reset_digits",  32'(dig),     32'd0);
    check("reset_ovf",     32'(ovf),     32'd0);
    check("reset_running", 32'(running), 32'd0);
    reset = 1'b0;

    for (int v = 0; v < 12; v++) begin
      run(vecs[v].clken, vecs[v].rst, vecs[v].cycles);
      check($sformatf("vec%0d_time", v), 32'(dig),     32'(vecs[v].exp_t));
      check($sformatf("vec%0d_run",  v), 32'(running), 32'(vecs[v].exp_run));
    end

    // asynchronous reset mid-count at 00:03.27, checked before the next edge
    reset = 1'b1;
    #1;
    check("async_digits",  32'(dig),     32'd0);
    check("async_ovf",     32'(ovf),     32'd0);
    check("async_running", 32'(running), 32'd0);
    @(posedge CLK);
    #1;
    reset = 1'b0;
    model_reset();

    // preload 59:59.99 while paused, then run across the wrap
    clken = 1'b0;
    force dut.u_m_hi.q  = 4'd5;
    force dut.u_m_lo.q  = 4'd9;
    force dut.u_s_hi.q  = 4'd5;
    force dut.u_s_lo.q  = 4'd9;
    force dut.u_hs_hi.q = 4'd9;
    force dut.u_hs_lo.q = 4'd9;
    #1;
    release dut.u_m_hi.q;
    release dut.u_m_lo.q;
    release dut.u_s_hi.q;
    release dut.u_s_lo.q;
    release dut.u_hs_hi.q;
    release dut.u_hs_lo.q;
    m_cnt = FULL - 1;
    run(1'b0, 1'b0, 1);
    check("preload", 32'(dig), 32'h595999);
    run(1'b1, 1'b0, 3);
    check("pre_wrap_time", 32'(dig), 32'h595999);
    check("pre_wrap_ovf",  32'(ovf), 32'd0);
    run(1'b1, 1'b0, 1);
    check("wrap_time", 32'(dig), 32'h000000);
    check("wrap_ovf",  32'(ovf), 32'd1);
    run(1'b1, 1'b0, 1);
    check("wrap_ovf_drop", 32'(ovf), 32'd0);
    run(1'b1, 1'b0, 3);
    check("post_wrap_time", 32'(dig), 32'h000001);
    check("post_wrap_ovf",  32'(ovf), 32'd0);

`ifdef LAP_HOLD_EN
    // lap hold: freeze at 00:05.00, live count moves on to 00:05.50
    run(1'b0, 1'b1, 1);
    run(1'b1, 1'b0, 2000);
    check("lap_start", 32'(dig), 32'h000500);
    cycle(1'b1, 1'b0, 1'b1);
    run(1'b1, 1'b0, 199);
    check("lap_frozen",  32'(dig),     32'h000500);
    check("lap_running", 32'(running), 32'd1);
    cycle(1'b1, 1'b0, 1'b1);
    check("lap_release", 32'(dig), 32'h000550);
`endif

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
